// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit scheduler: size defaults, FSM states
// and the {CKP,CPH} mode encoding.
package spi_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // mode = {CKP, CPH}
    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;
    localparam logic [1:0] MODE_2 = 2'b10;
    localparam logic [1:0] MODE_3 = 2'b11;

    function automatic logic [1:0] mode_of(input logic ckp, input logic cph);
        return {ckp, cph};
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock circular FIFO: push/pop with occupancy count, head word always
// visible on dout_o.
module spi_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          din_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          dout_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    // Overflow and underflow requests are dropped here, not just at the top.
    assign do_push = push_i && (level_q < LVL_W'(DEPTH));
    assign do_pop  = pop_i  && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/spi_tx_scheduler.sv
// Drains a word FIFO into an SPI master one frame at a time, latching the
// mode bits per frame, enforcing an inter-frame gap and a WAIT timeout.
module spi_tx_scheduler
    import spi_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int GAP_CYC = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    input  logic                   cfg_ckp,
    input  logic                   cfg_cph,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   tx_start,
    output logic                   CKP,
    output logic                   CPH,
    input  logic                   tx_done,
    output logic [$clog2(DEPTH):0] level,
    output logic                   timeout_err
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] tx_data_q;
    logic [1:0]        mode_q;
    logic              tx_start_q;
    logic              err_q;
    logic              err_set;

    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_push, fifo_pop;

    assign wr_ready  = (fifo_level < LVL_W'(DEPTH));
    assign fifo_push = wr_valid && wr_ready;
    assign fifo_pop  = (state_q == ST_LOAD);

    spi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (wr_data),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        err_set   = 1'b0;
        case (state_q)
            ST_IDLE:  if (fifo_level != '0) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_START;
            ST_START: begin
                state_d   = ST_WAIT;
                tmo_cnt_d = '0;
            end
            // The counter value TIMEOUT-1 marks the TIMEOUT-th cycle spent here.
            ST_WAIT: begin
                if (tx_done) begin
                    state_d   = ST_GAP;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d   = ST_GAP;
                    tmo_cnt_d = '0;
                    err_set   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tx_data_q  <= '0;
            mode_q     <= MODE_0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_start_q <= (state_d == ST_START);
            // Word and mode are captured together so they stay paired for the frame.
            if (state_q == ST_LOAD) begin
                tx_data_q <= fifo_head;
                mode_q    <= mode_of(cfg_ckp, cfg_cph);
            end
            if (err_set)
                err_q <= 1'b1;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign {CKP, CPH}  = mode_q;
    assign level       = fifo_level;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler with hand-computed expectations.
module tb_spi_tx_scheduler;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        reset, wr_valid, wr_ready, cfg_ckp, cfg_cph;
    logic        tx_start, CKP, CPH, tx_done, timeout_err;
    logic [15:0] wr_data, tx_data;
    logic [2:0]  level;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    spi_tx_scheduler #(
        .DATA_W  (16),
        .DEPTH   (4),
        .GAP_CYC (4),
        .TIMEOUT (1023)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .cfg_ckp     (cfg_ckp),
        .cfg_cph     (cfg_cph),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .CKP         (CKP),
        .CPH         (CPH),
        .tx_done     (tx_done),
        .level       (level),
        .timeout_err (timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        bit rdy = 0;
        for (int n = 0; n < 50; n++) begin
            if (wr_ready) begin rdy = 1; break; end
            step();
        end
        chk("push_ready", 32'(rdy), 32'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        bit seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (tx_start) begin seen = 1; break; end
            step();
        end
        chk({tag, "_start"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_state(input string tag, input state_e s);
        bit seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (dut.state_q == s) begin seen = 1; break; end
            step();
        end
        chk({tag, "_state"}, 32'(seen), 32'd1);
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; tx_done = 1'b0;
        cfg_ckp = 1'b0; cfg_cph = 1'b0;

        // Reset state; writes offered during reset are refused
        step();
        wr_valid = 1'b1; wr_data = 16'hDEAD;
        step(); step();
        chk("rst_level",   32'(level), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_mode",    32'({CKP, CPH}), 32'd0);
        chk("rst_err",     32'(timeout_err), 32'd0);
        chk("rst_state",   32'(dut.state_q), 32'(ST_IDLE));
        wr_valid = 1'b0;
        reset = 1'b0;
        step();
        chk("rst_no_write", 32'(level), 32'd0);

        // Single frame, mode 01, latency k+2, GAP of 4
        cfg_ckp = 1'b0; cfg_cph = 1'b1;
        push(16'hA5C3);
        chk("t1_level_k", 32'(level), 32'd1);
        chk("t1_start_k", 32'(tx_start), 32'd0);
        step();
        chk("t1_start_k1", 32'(tx_start), 32'd0);
        step();
        chk("t1_start_k2", 32'(tx_start), 32'd1);
        chk("t1_data", 32'(tx_data), 32'hA5C3);
        chk("t1_mode", 32'({CKP, CPH}), 32'b01);
        step();
        chk("t1_start_pulse", 32'(tx_start), 32'd0);
        repeat (18) step();
        done_pulse();
        chk("t1_gap", 32'(dut.state_q), 32'(ST_GAP));
        repeat (3) step();
        chk("t1_gap3", 32'(dut.state_q), 32'(ST_GAP));
        chk("t1_hold", 32'(tx_data), 32'hA5C3);
        step();
        chk("t1_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Burst of 5 while a frame is in WAIT: 4 fit, 5th after the next LOAD
        push(16'h00FF);
        wait_start("t2_f0");
        step();
        for (int i = 1; i <= 4; i++) push(16'(i));
        chk("t2_level4", 32'(level), 32'd4);
        chk("t2_full_rdy", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1; wr_data = 16'h0005;
        repeat (3) step();
        chk("t2_held", 32'(level), 32'd4);
        done_pulse();
        begin
            bit got5 = 0;
            for (int n = 0; n < 30; n++) begin
                if (wr_ready) begin
                    chk("t2_w5_after_load", 32'(dut.state_q), 32'(ST_START));
                    chk("t2_order1", 32'(tx_data), 32'h0001);
                    got5 = 1;
                    step();
                    break;
                end
                step();
            end
            wr_valid = 1'b0;
            chk("t2_w5_accepted", 32'(got5), 32'd1);
        end
        chk("t2_level_after5", 32'(level), 32'd4);
        done_pulse();
        for (int i = 2; i <= 5; i++) begin
            wait_start("t2_f");
            chk($sformatf("t2_order%0d", i), 32'(tx_data), 32'(i));
            step();
            done_pulse();
        end

        // Fill to 3, simultaneous push/pop at LOAD, order across pointer wrap
        push(16'h0A00);
        wait_start("t3_f0");
        chk("t3_d0", 32'(tx_data), 32'h0A00);
        step();
        for (int i = 1; i <= 3; i++) push(16'h0A00 + 16'(i));
        chk("t3_level3", 32'(level), 32'd3);
        done_pulse();
        wait_state("t3_load", ST_LOAD);
        wr_valid = 1'b1; wr_data = 16'h0A04;
        step();
        wr_valid = 1'b0;
        chk("t3_level_same", 32'(level), 32'd3);
        chk("t3_start1", 32'(tx_start), 32'd1);
        chk("t3_d1", 32'(tx_data), 32'h0A01);
        step();
        done_pulse();
        for (int i = 2; i <= 4; i++) begin
            wait_start("t3_f");
            chk($sformatf("t3_d%0d", i), 32'(tx_data), 32'h0A00 + 32'(i));
            step();
            done_pulse();
        end

        // Timeout after 1023 WAIT cycles; next word still launches
        push(16'h0B00);
        wait_start("t4_f0");
        step();
        push(16'h0B01);
        repeat (1021) step();
        chk("t4_err_early", 32'(timeout_err), 32'd0);
        chk("t4_still_wait", 32'(dut.state_q), 32'(ST_WAIT));
        step();
        chk("t4_err_set", 32'(timeout_err), 32'd1);
        chk("t4_gap", 32'(dut.state_q), 32'(ST_GAP));
        wait_start("t4_f1");
        chk("t4_d1", 32'(tx_data), 32'h0B01);
        chk("t4_err_sticky", 32'(timeout_err), 32'd1);
        step();
        done_pulse();

        // Mode change during WAIT only takes effect at the next LOAD
        cfg_ckp = 1'b0; cfg_cph = 1'b0;
        push(16'h0C00);
        wait_start("t5_f0");
        chk("t5_mode00", 32'({CKP, CPH}), 32'b00);
        step();
        push(16'h0C01);
        cfg_ckp = 1'b1; cfg_cph = 1'b1;
        repeat (3) step();
        chk("t5_mode_hold", 32'({CKP, CPH}), 32'b00);
        done_pulse();
        wait_start("t5_f1");
        chk("t5_d1", 32'(tx_data), 32'h0C01);
        chk("t5_mode11", 32'({CKP, CPH}), 32'b11);
        step();

        // Reset in WAIT with 2 queued words
        push(16'h0D01);
        push(16'h0D02);
        chk("t6_level2", 32'(level), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("t6_err", 32'(timeout_err), 32'd0);
        chk("t6_mode", 32'({CKP, CPH}), 32'b00);
        begin
            int starts = 0;
            repeat (12) begin
                step();
                if (tx_start) starts++;
            end
            chk("t6_no_start", 32'(starts), 32'd0);
        end
        chk("t6_level_end", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_tx_scheduler.md
SPI_TX_SCHEDULER -- requirements
Module: spi_tx_scheduler

Interface
REQ-001 Parameter DATA_W, default 16, SPI frame width in bits.
REQ-002 Parameter DEPTH, default 4, FIFO depth in words; power of two.
REQ-003 Parameter GAP_CYC, default 4, minimum clk cycles between tx_done and the next tx_start.
REQ-004 Parameter TIMEOUT, default 1023, maximum clk cycles in WAIT before abort.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wr_valid  in  1  producer offers wr_data.
REQ-008 wr_data  in  DATA_W  word to transmit.
REQ-009 wr_ready  out  1  FIFO can accept; a word is transferred on an edge where wr_valid && wr_ready.
REQ-010 cfg_ckp, cfg_cph  in  1 each  requested SPI clock polarity and phase for the next frame.
REQ-011 tx_data  out  DATA_W  word presented to generador_spi.
REQ-012 tx_start  out  1  one-cycle pulse that launches a master frame.
REQ-013 CKP, CPH  out  1 each  mode bits driven to the master and receptors, stable from LOAD until the frame ends.
REQ-014 tx_done  in  1  one-cycle pulse from the master at frame end (CS released).
REQ-015 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 timeout_err  out  1  sticky flag, set when a frame is aborted.

Function
REQ-017 wr_ready SHALL equal (level < DEPTH), combinational from the registered level; there is no full-FIFO pass-through.
REQ-018 The FIFO SHALL use circular read and write pointers that wrap from DEPTH-1 to 0; a push and a pop on the same edge leave level unchanged.
REQ-019 The FSM states SHALL be IDLE, LOAD, START, WAIT and GAP.
REQ-020 IDLE -> LOAD when level > 0; otherwise remain in IDLE.
REQ-021 LOAD SHALL pop the head word into tx_data, latch cfg_ckp/cfg_cph into CKP/CPH, and go to START.
REQ-022 START SHALL drive tx_start = 1 for exactly one cycle and go to WAIT; tx_start is 0 in every other state.
REQ-023 WAIT SHALL go to GAP on tx_done. Otherwise it increments the timeout counter, and when the counter reaches TIMEOUT it sets timeout_err and goes to GAP.
REQ-024 tx_done received outside WAIT SHALL be ignored.
REQ-025 GAP SHALL hold for GAP_CYC cycles, then return to IDLE.
REQ-026 Latency: a word accepted on edge k into an empty FIFO with the FSM in IDLE SHALL produce tx_start high during cycle k+2.
REQ-027 tx_data, CKP and CPH SHALL remain constant from LOAD through the end of GAP; a cfg_ckp/cfg_cph change only affects the next LOAD.
REQ-028 A write attempted while full is not accepted: no data loss and no error; the producer holds wr_valid.
REQ-029 timeout_err SHALL stay set until reset; it does not stop further frames.

Reset
REQ-030 On reset, synchronously: state = IDLE, pointers = 0, level = 0, tx_data = 0, tx_start = 0, CKP = 0, CPH = 0, timeout_err = 0, and the gap and timeout counters = 0.
REQ-031 Reset asserted mid-frame SHALL abort immediately; the FIFO contents are discarded and tx_start is not reissued.
REQ-032 While reset is high, wr_ready SHALL read 1 (level = 0) but no write is accepted.

Structure
REQ-033 A shared package spi_pkg SHALL hold the FSM state enum, the DATA_W/DEPTH defaults and the mode encodings (mode = {CKP,CPH}).
REQ-034 The FIFO SHALL be one sub-module, spi_sync_fifo (push/pop/level, no FSM); the FSM and counters stay in spi_tx_scheduler.

Verification
REQ-035 Single write 16'hA5C3, mode 2'b01 -> tx_start pulses at k+2; tx_data = 16'hA5C3, CKP = 0, CPH = 1; a tx_done 20 cycles later leads to IDLE after 4 GAP cycles.
REQ-036 Burst of 5 writes 16'h0001..16'h0005 with no pops -> 4 accepted; wr_ready = 0 at level = 4; the 5th word is accepted only after the first LOAD; frames are sent in order 1..5.
REQ-037 Fill to 3, then push and pop on the same edge -> level stays 3; the pointer wrap past index 3 preserves order.
REQ-038 No tx_done for 1023 cycles in WAIT -> timeout_err = 1, GAP entered, and the next queued word is launched normally.
REQ-039 cfg toggled from 2'b00 to 2'b11 during WAIT -> CKP/CPH unchanged until the next LOAD, then 1/1.
REQ-040 Reset pulsed in WAIT with 2 words queued -> level = 0, state = IDLE, no tx_start after reset, timeout_err = 0.
